pu_fifo_mc: RTL and testbench

PU_FIFO_MC -- requirements
Module: pu_fifo_mc

---
 rtl/pu_fifo_mc.sv | 93 +++++++++
 tb/tb_pu_fifo_mc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pu_fifo_mc.sv
// pu_fifo_mc: multi-channel circular FIFO with a zero-latency pop path and sticky error flags.
// Each channel has its own pointers and occupancy count; storage is not reset.
module pu_fifo_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int FIFO_SIZE  = 8,
   parameter int CHANNELS   = 2,
   localparam int ADDR_WIDTH = $clog2(FIFO_SIZE),
   localparam int CH_WIDTH   = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   input  logic                  signal_wr,
   input  logic [CH_WIDTH-1:0]   signal_wr_ch,
   input  logic                  signal_oe,
   input  logic [CH_WIDTH-1:0]   signal_oe_ch,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out,
   output logic [CHANNELS-1:0]   full,
   output logic [CHANNELS-1:0]   empty,
   output logic                  err_overflow,
   output logic                  err_underflow
);
   localparam int W  = ATTR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(FIFO_SIZE + 1);

   logic [W-1:0]          mem    [CHANNELS][FIFO_SIZE];
   logic [ADDR_WIDTH-1:0] wr_ptr [CHANNELS];
   logic [ADDR_WIDTH-1:0] rd_ptr [CHANNELS];
   logic [CW-1:0]         count  [CHANNELS];
   logic [CHANNELS-1:0]   rd_hit, wr_hit, do_rd, do_wr;
   logic [W-1:0]          word;
   logic                  overflow, underflow;

   function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] p);
      return p == ADDR_WIDTH'(FIFO_SIZE - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full  = '0;
      empty = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         empty[i] = count[i] == '0;
         full[i]  = count[i] == CW'(FIFO_SIZE);
      end
   end

   // Channel codes with no matching channel hit nothing, so they are ignored and read as empty.
   always_comb begin
      rd_hit = '0;
      wr_hit = '0;
      do_rd  = '0;
      do_wr  = '0;
      word   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rd_hit[i] = signal_oe && signal_oe_ch == CH_WIDTH'(i);
         wr_hit[i] = signal_wr && signal_wr_ch == CH_WIDTH'(i);
         do_rd[i]  = rd_hit[i] && !empty[i];
         do_wr[i]  = wr_hit[i] && (!full[i] || do_rd[i]);
         word      = do_rd[i] ? mem[i][rd_ptr[i]] : word;
      end
      underflow = signal_oe && !(|do_rd);
      overflow  = |(wr_hit & ~do_wr);
   end

   assign data_out = word[DATA_WIDTH-1:0];
   assign attr_out = underflow ? ATTR_WIDTH'(1) : word[W-1:DATA_WIDTH];

   always_ff @(posedge clk)
      for (int i = 0; i < CHANNELS; i++)
         if (do_wr[i]) mem[i][wr_ptr[i]] <= {attr_in, data_in};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            wr_ptr[i] <= do_wr[i] ? nxt(wr_ptr[i]) : wr_ptr[i];
            rd_ptr[i] <= do_rd[i] ? nxt(rd_ptr[i]) : rd_ptr[i];
            count[i]  <= count[i] + CW'(do_wr[i]) - CW'(do_rd[i]);
         end
         err_overflow  <= err_overflow | overflow;
         err_underflow <= err_underflow | underflow;
      end
endmodule

// File: tb/tb_pu_fifo_mc.sv
// tb_pu_fifo_mc: scoreboard bench for pu_fifo_mc with three channels of three entries each.
// Pushed words queue per channel; pops compare the live output against the queue head.
module tb_pu_fifo_mc;
   localparam int DW = 32, AW = 4, FS = 3, CH = 3, CHW = 2;

   logic          clk = 0, rst = 1;
   logic [DW-1:0] data_in = 0;
   logic [AW-1:0] attr_in = 0;
   logic          signal_wr = 0, signal_oe = 0;
   logic [CHW-1:0] signal_wr_ch = 0, signal_oe_ch = 0;
   logic [DW-1:0] data_out;
   logic [AW-1:0] attr_out;
   logic [CH-1:0] full, empty;
   logic          err_overflow, err_underflow;

   logic [AW+DW-1:0] q [CH][$];
   logic             m_ov = 0, m_uf = 0;
   int               checks = 0, errors = 0;

   pu_fifo_mc #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .FIFO_SIZE(FS), .CHANNELS(CH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .attr_in(attr_in),
      .signal_wr(signal_wr), .signal_wr_ch(signal_wr_ch),
      .signal_oe(signal_oe), .signal_oe_ch(signal_oe_ch),
      .data_out(data_out), .attr_out(attr_out), .full(full), .empty(empty),
      .err_overflow(err_overflow), .err_underflow(err_underflow));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      logic [CH-1:0] e_full, e_empty;
      for (int c = 0; c < CH; c++) begin
         e_full[c]  = q[c].size() == FS;
         e_empty[c] = q[c].size() == 0;
      end
      check({tag, ".full"}, 64'(full), 64'(e_full));
      check({tag, ".empty"}, 64'(empty), 64'(e_empty));
      check({tag, ".ovf"}, 64'(err_overflow), 64'(m_ov));
      check({tag, ".udf"}, 64'(err_underflow), 64'(m_uf));
   endtask

   task automatic cyc(input logic wr, input int wch, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input logic oe, input int och);
      logic [AW+DW-1:0] exp;
      logic pop_ok, push_ok;
      @(negedge clk);
      signal_wr = wr; signal_wr_ch = CHW'(wch); data_in = d; attr_in = a;
      signal_oe = oe; signal_oe_ch = CHW'(och);
      pop_ok  = oe && och < CH && q[och].size() > 0;
      push_ok = wr && wch < CH && (q[wch].size() < FS || (pop_ok && och == wch));
      exp = !oe ? '0 : pop_ok ? q[och][0] : {AW'(1), DW'(0)};
      #1 check("out", 64'({attr_out, data_out}), 64'(exp));
      @(posedge clk);
      if (pop_ok) void'(q[och].pop_front());
      if (push_ok) q[wch].push_back({a, d});
      if (oe && !pop_ok) m_uf = 1;
      if (wr && wch < CH && !push_ok) m_ov = 1;
      #1 check_status("cyc");
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d);
      cyc(1, ch, d, AW'(d >> 4), 0, 0);
   endtask

   task automatic pop(input int ch);
      cyc(0, 0, 0, 0, 1, ch);
   endtask

   task automatic async_reset;
      @(negedge clk);
      signal_wr = 0; signal_oe = 0;
      #2 rst = 1;
      for (int c = 0; c < CH; c++) q[c].delete();
      m_ov = 0; m_uf = 0;
      #1 check_status("rst_async");
      check("rst_out", 64'({attr_out, data_out}), 64'(0));
      @(negedge clk) rst = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_status("reset");
      check("reset_out", 64'({attr_out, data_out}), 64'(0));
      rst = 0;
      // in-order single channel
      push(0, 32'hA); push(0, 32'hB); push(0, 32'hC);
      pop(0); pop(0); pop(0);
      // underflow on empty channel
      pop(0);
      // overflow: five pushes into three entries
      for (int i = 1; i <= 5; i++) push(1, 32'h100 + i);
      repeat (3) pop(1);
      // full channel accepts a push when popped in the same cycle
      push(0, 32'h1); push(0, 32'h2); push(0, 32'h3);
      cyc(1, 0, 32'h55, 4'h2, 1, 0);
      repeat (3) pop(0);
      // push and pop on different channels
      push(1, 32'h22);
      cyc(1, 0, 32'h11, 4'h4, 1, 1);
      pop(0);
      // out-of-range channel code
      cyc(1, 3, 32'hDEAD, 4'h6, 1, 3);
      // same-channel push+pop on empty: stored, no bypass
      cyc(1, 2, 32'h77, 4'h8, 1, 2);
      pop(2);
      // random traffic exercises pointer wrap on all channels
      for (int i = 0; i < 60; i++)
         cyc(1'($urandom), int'($urandom_range(0, 3)), $urandom, 4'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
      // asynchronous reset mid-operation discards queued data
      async_reset;
      push(0, 32'hE1); push(0, 32'hE2);
      async_reset;
      push(0, 32'hF0);
      pop(0);
      pop(0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
